// File: rtl/countdown_timer_if.sv
// Bus bundle for countdown_timer: user controls in, count and status flags out.
// The master modport is the controlling side, the slave modport is the timer.
interface countdown_timer_if;
    logic       go;
    logic       clear;
    logic       load;
    logic [7:0] load_val;
    logic [7:0] val;
    logic       running;
    logic       tick;
    logic       expired;

    modport master (
        output go,
        output clear,
        output load,
        output load_val,
        input  val,
        input  running,
        input  tick,
        input  expired
    );

    modport slave (
        input  go,
        input  clear,
        input  load,
        input  load_val,
        output val,
        output running,
        output tick,
        output expired
    );
endinterface

// File: rtl/countdown_timer.sv
// Seconds countdown timer for a two-digit seven-segment display.
// A free-running prescaler divides the board clock down to count steps; the
// count runs down from a loaded or default value and flags expiry at zero.
// Controls (go/clear/load) are level inputs acted on at their rising edge.
module countdown_timer #(
    parameter int TICK_DIV  = 50_000_000,
    parameter int START_VAL = 60,
    parameter int MAX_VAL   = 99
) (
    input  logic             i_clk,
    input  logic             i_rst,
    countdown_timer_if.slave bus
);

    localparam int             PW        = $clog2(TICK_DIV);
    localparam logic [PW-1:0]  PRESC_TOP = PW'(TICK_DIV - 1);
    localparam logic [7:0]     START_V   = 8'(START_VAL);
    localparam logic [7:0]     MAX_V     = 8'(MAX_VAL);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Clamp a user load value to the two-digit ceiling (no wrap-around).
    function automatic logic [7:0] sat_load(input logic [7:0] v);
        if (v > MAX_V) begin
            sat_load = MAX_V;
        end else begin
            sat_load = v;
        end
    endfunction

    state_t         r_state;
    logic [PW-1:0]  r_presc;
    logic [7:0]     r_val;
    logic           r_running;
    logic           r_tick;
    logic           r_expired;
    logic           r_go_prev;
    logic           r_clear_prev;
    logic           r_load_prev;

    logic           w_e_go;
    logic           w_e_clear;
    logic           w_e_load;
    logic [7:0]     w_load_sat;

    // History regs reset to 1 so a control held high through reset release
    // is not mistaken for a fresh press.
    assign w_e_go     = bus.go    & ~r_go_prev;
    assign w_e_clear  = bus.clear & ~r_clear_prev;
    assign w_e_load   = bus.load  & ~r_load_prev;
    assign w_load_sat = sat_load(bus.load_val);

    // Timer FSM: edge history, prescaler, count and registered status flags.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_go_prev    <= 1'b1;
            r_clear_prev <= 1'b1;
            r_load_prev  <= 1'b1;
            r_state      <= ST_IDLE;
            r_presc      <= '0;
            r_val        <= START_V;
            r_running    <= 1'b0;
            r_tick       <= 1'b0;
            r_expired    <= 1'b0;
        end else begin
            r_go_prev    <= bus.go;
            r_clear_prev <= bus.clear;
            r_load_prev  <= bus.load;
            r_tick       <= 1'b0;

            // clear beats load beats go beats the count step
            if (w_e_clear) begin
                r_val     <= START_V;
                r_state   <= ST_IDLE;
                r_presc   <= '0;
                r_running <= 1'b0;
                r_expired <= 1'b0;
            end else if (w_e_load) begin
                r_val     <= w_load_sat;
                r_state   <= ST_IDLE;
                r_presc   <= '0;
                r_running <= 1'b0;
                r_expired <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_presc   <= '0;
                        r_expired <= 1'b0;
                        // starting from zero would expire with no count; refuse it
                        if (w_e_go && (r_val != 8'd0)) begin
                            r_state   <= ST_RUN;
                            r_running <= 1'b1;
                        end else begin
                            r_state   <= ST_IDLE;
                            r_running <= 1'b0;
                        end
                    end
                    ST_RUN: begin
                        if (w_e_go) begin
                            // pause wins over a coinciding wrap; the prescaler
                            // keeps its value so the partial second resumes
                            r_state   <= ST_PAUSED;
                            r_running <= 1'b0;
                        end else if (r_presc == PRESC_TOP) begin
                            r_presc <= '0;
                            r_tick  <= 1'b1;
                            if (r_val <= 8'd1) begin
                                r_val     <= 8'd0;
                                r_state   <= ST_DONE;
                                r_running <= 1'b0;
                                r_expired <= 1'b1;
                            end else begin
                                r_val <= r_val - 8'd1;
                            end
                        end else begin
                            r_presc <= r_presc + PW'(1);
                        end
                    end
                    ST_PAUSED: begin
                        if (w_e_go) begin
                            r_state   <= ST_RUN;
                            r_running <= 1'b1;
                        end else begin
                            r_state   <= ST_PAUSED;
                            r_running <= 1'b0;
                        end
                    end
                    ST_DONE: begin
                        r_presc   <= '0;
                        r_val     <= 8'd0;
                        r_running <= 1'b0;
                        r_expired <= 1'b1;
                    end
                    default: begin
                        r_state   <= ST_IDLE;
                        r_presc   <= '0;
                        r_val     <= START_V;
                        r_running <= 1'b0;
                        r_expired <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.val     = r_val;
    assign bus.running = r_running;
    assign bus.tick    = r_tick;
    assign bus.expired = r_expired;

    countdown_timer_chk #(
        .MAX_VAL (MAX_VAL)
    ) u_chk (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_val     (r_val),
        .i_running (r_running),
        .i_expired (r_expired)
    );

endmodule

// Invariant checks on the timer outputs, kept apart from the datapath.
module countdown_timer_chk #(
    parameter int MAX_VAL = 99
) (
    input logic       i_clk,
    input logic       i_rst,
    input logic [7:0] i_val,
    input logic       i_running,
    input logic       i_expired
);
    localparam logic [7:0] MAX_V = 8'(MAX_VAL);

    a_val_range: assert property (@(posedge i_clk) disable iff (i_rst)
        i_val <= MAX_V);
    a_run_xor_done: assert property (@(posedge i_clk) disable iff (i_rst)
        !(i_running && i_expired));
    a_done_zero: assert property (@(posedge i_clk) disable iff (i_rst)
        i_expired |-> (i_val == 8'd0));
endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer (TICK_DIV=4, START_VAL=60, MAX_VAL=99).
// Stimulus pushes the hand-computed tick events it expects; a monitor pops
// and compares on every tick pulse. State checks are made at quiet points.
module tb_countdown_timer;
    typedef struct {
        int         cyc;
        logic [7:0] val;
        logic       run;
        logic       exp;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   n_pass;
    int   n_total;
    exp_t q[$];

    countdown_timer_if ifc ();

    countdown_timer #(
        .TICK_DIV  (4),
        .START_VAL (60),
        .MAX_VAL   (99)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        n_total++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    endtask

    // expected ticks of a run from start_v, the first decrement at first_cyc
    task automatic push_ticks(input int first_cyc, input int start_v);
        exp_t e;
        for (int k = 0; k < start_v; k++) begin
            e.cyc = first_cyc + 4 * k;
            e.val = 8'(start_v - 1 - k);
            e.run = (k != start_v - 1);
            e.exp = (k == start_v - 1);
            q.push_back(e);
        end
    endtask

    task automatic do_load(input int v);
        @(negedge clk);
        ifc.load_val = 8'(v);
        ifc.load     = 1'b1;
        @(negedge clk);
        ifc.load     = 1'b0;
    endtask

    // returns the clock edge number on which the go press acts
    task automatic do_go(output int edge_n);
        @(negedge clk);
        ifc.go = 1'b1;
        edge_n = cyc + 1;
        @(negedge clk);
        ifc.go = 1'b0;
    endtask

    // monitor: every tick pulse must match the head of the scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (ifc.tick) begin
            if (q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_tick: got tick at cycle %0d val %0d expected none", cyc, ifc.val);
            end else begin
                e = q.pop_front();
                check("tick_cycle", cyc, e.cyc);
                check("tick_val", int'(ifc.val), int'(e.val));
                check("tick_running", int'(ifc.running), int'(e.run));
                check("tick_expired", int'(ifc.expired), int'(e.exp));
            end
        end
    end

    initial begin
        int e0;
        int e1;
        cyc     = 0;
        n_pass  = 0;
        n_total = 0;
        rst          = 1'b1;
        ifc.go       = 1'b0;
        ifc.clear    = 1'b0;
        ifc.load     = 1'b0;
        ifc.load_val = 8'd0;

        // 1: reset values, then idle for 10 cycles with no change
        repeat (3) @(negedge clk);
        check("rst_val", int'(ifc.val), 60);
        check("rst_running", int'(ifc.running), 0);
        check("rst_tick", int'(ifc.tick), 0);
        check("rst_expired", int'(ifc.expired), 0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("idle_hold_val", int'(ifc.val), 60);
        check("idle_hold_running", int'(ifc.running), 0);

        // 2: load 5 and run to expiry
        do_load(5);
        check("load5_val", int'(ifc.val), 5);
        do_go(e0);
        check("run_running", int'(ifc.running), 1);
        push_ticks(e0 + 4, 5);
        repeat (20) @(negedge clk);
        check("done_expired", int'(ifc.expired), 1);
        check("done_running", int'(ifc.running), 0);
        check("done_val", int'(ifc.val), 0);
        do_go(e1);
        check("done_go_ignored", int'(ifc.expired), 1);

        // 3: pause with the prescaler at 2, resume finishes the partial second
        do_load(5);
        check("reload_expired", int'(ifc.expired), 0);
        do_go(e0);
        @(negedge clk);
        do_go(e1);
        check("pause_running", int'(ifc.running), 0);
        repeat (10) @(negedge clk);
        check("pause_val_frozen", int'(ifc.val), 5);
        check("pause_running_held", int'(ifc.running), 0);
        do_go(e1);
        check("resume_running", int'(ifc.running), 1);
        push_ticks(e1 + 2, 5);
        repeat (19) @(negedge clk);
        check("resume_done_expired", int'(ifc.expired), 1);

        // 4: saturating load, and go refused at zero
        do_load(200);
        check("sat_val", int'(ifc.val), 99);
        do_load(0);
        check("zero_val", int'(ifc.val), 0);
        do_go(e0);
        check("zero_go_running", int'(ifc.running), 0);
        check("zero_go_expired", int'(ifc.expired), 0);

        // 5: clear and load together while running -> clear wins
        do_load(30);
        do_go(e0);
        @(negedge clk);
        ifc.clear    = 1'b1;
        ifc.load     = 1'b1;
        ifc.load_val = 8'd10;
        @(negedge clk);
        ifc.clear = 1'b0;
        ifc.load  = 1'b0;
        check("clr_load_val", int'(ifc.val), 60);
        check("clr_load_running", int'(ifc.running), 0);

        // go held high across reset release must not start the timer
        ifc.go = 1'b1;
        rst    = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("held_go_no_start", int'(ifc.running), 0);
        ifc.go = 1'b0;
        do_go(e0);
        check("rego_running", int'(ifc.running), 1);

        // 6: asynchronous reset mid-run acts before the next clock edge
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_val", int'(ifc.val), 60);
        check("async_rst_running", int'(ifc.running), 0);
        @(negedge clk);
        rst = 1'b0;
        do_load(1);
        do_go(e0);
        push_ticks(e0 + 4, 1);
        repeat (4) @(negedge clk);
        check("done1_expired", int'(ifc.expired), 1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_done_expired", int'(ifc.expired), 0);
        check("async_rst_done_val", int'(ifc.val), 60);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        n_total++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL missing_ticks: got %0d ticks outstanding expected 0", q.size());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
